// File: rtl/seq_bit_checker_pkg.sv
// Shared definitions for the sequential bit checker: FSM encoding,
// observed-state width and the next-a prediction function.
package seq_bit_checker_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } fsm_t;

  // Next value of a given the current observed state {a,b,c,d}, a = MSB.
  function automatic logic next_a(input logic [STATE_W-1:0] s);
    logic a, b, c, d;
    {a, b, c, d} = s;
    return (~a & b & c & d) | (a & ~c & d) | (a & ~b & c) | (a & c & ~d);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module seq_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Count enabled increments, holding once every bit is set.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/seq_bit_checker.sv
// Checks an observed 4-bit state stream against the predicted next a bit.
// The first enabled sample after IDLE only primes the prediction; every
// following enabled sample is compared against it and reloads it.
module seq_bit_checker
  import seq_bit_checker_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               en,
  input  logic [STATE_W-1:0] state_in,
  output logic               pred_a,
  output logic               pred_valid,
  output logic               mismatch,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   chk_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [STATE_W-1:0] first_err,
  output logic [1:0]         fsm_state
);

  fsm_t state;
  fsm_t state_next;

  logic do_prime;
  logic do_compare;
  logic do_fail;
  logic do_drop;
  logic do_halt;

  // Hold the current FSM state; clear always returns to IDLE.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Choose the next state from the current state, enable and compare result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (en) state_next = PRIME;
      end
      PRIME, CHECK: begin
        if (!en) begin
          state_next = IDLE;
        end else if (do_halt) begin
          state_next = HALT;
        end else begin
          state_next = CHECK;
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Decode which action this edge performs; HALT ignores en entirely.
  always_comb begin
    do_prime   = (state == IDLE) && en;
    do_compare = ((state == PRIME) || (state == CHECK)) && en;
    do_fail    = do_compare && (state_in[STATE_W-1] != pred_a);
    do_drop    = ((state == PRIME) || (state == CHECK)) && !en;
    do_halt    = do_fail && STOP_ON_ERR;
  end

  // Register the prediction, error pulse and first-failure capture.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pred_a     <= 1'b0;
      pred_valid <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      first_err  <= '0;
    end else begin
      mismatch <= do_fail;
      if (do_prime || do_compare) begin
        pred_a <= next_a(state_in);
      end
      if (do_prime) begin
        pred_valid <= 1'b1;
      end else if (do_drop || do_halt) begin
        pred_valid <= 1'b0;
      end
      if (do_fail) begin
        err_sticky <= 1'b1;
        if (!err_sticky) begin
          first_err <= state_in;
        end
      end
    end
  end

  seq_sat_counter #(.WIDTH(CNT_W)) u_chk_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (do_compare),
    .count (chk_cnt)
  );

  seq_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (do_fail),
    .count (err_cnt)
  );

  assign fsm_state = state;

endmodule

// File: tb/tb_seq_bit_checker.sv
// Scoreboard bench for seq_bit_checker: two instances share stimulus, one
// with defaults and one with a 2-bit counter width and stop-on-error set.
module tb_seq_bit_checker;

  logic       clk = 1'b0;
  logic       clear;
  logic       en;
  logic [3:0] state_in;

  logic       p0_pred_a, p0_pred_valid, p0_mismatch, p0_err_sticky;
  logic [7:0] p0_chk_cnt, p0_err_cnt;
  logic [3:0] p0_first_err;
  logic [1:0] p0_fsm_state;

  logic       p1_pred_a, p1_pred_valid, p1_mismatch, p1_err_sticky;
  logic [1:0] p1_chk_cnt, p1_err_cnt;
  logic [3:0] p1_first_err;
  logic [1:0] p1_fsm_state;

  seq_bit_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .clear(clear), .en(en), .state_in(state_in),
    .pred_a(p0_pred_a), .pred_valid(p0_pred_valid), .mismatch(p0_mismatch),
    .err_sticky(p0_err_sticky), .chk_cnt(p0_chk_cnt), .err_cnt(p0_err_cnt),
    .first_err(p0_first_err), .fsm_state(p0_fsm_state)
  );

  seq_bit_checker #(.CNT_W(2), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .clear(clear), .en(en), .state_in(state_in),
    .pred_a(p1_pred_a), .pred_valid(p1_pred_valid), .mismatch(p1_mismatch),
    .err_sticky(p1_err_sticky), .chk_cnt(p1_chk_cnt), .err_cnt(p1_err_cnt),
    .first_err(p1_first_err), .fsm_state(p1_fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pred_a;
    logic       pred_valid;
    logic       mismatch;
    logic       err_sticky;
    int         chk_cnt;
    int         err_cnt;
    logic [3:0] first_err;
    logic [1:0] fsm_state;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t model [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t mon_e;
  int   cnt_max [2];
  bit   stop_mode [2];
  // Truth table of the next-a rule: a goes high from states 7,9,10,11,13,14.
  logic [15:0] da_table = 16'h6E80;

  function automatic exp_t zeroExp();
    exp_t e;
    e.pred_a = 1'b0; e.pred_valid = 1'b0; e.mismatch = 1'b0; e.err_sticky = 1'b0;
    e.chk_cnt = 0; e.err_cnt = 0; e.first_err = 4'b0000; e.fsm_state = 2'd0;
    return e;
  endfunction

  function automatic exp_t actual0();
    exp_t a;
    a.pred_a = p0_pred_a; a.pred_valid = p0_pred_valid; a.mismatch = p0_mismatch;
    a.err_sticky = p0_err_sticky; a.chk_cnt = int'(p0_chk_cnt); a.err_cnt = int'(p0_err_cnt);
    a.first_err = p0_first_err; a.fsm_state = p0_fsm_state;
    return a;
  endfunction

  function automatic exp_t actual1();
    exp_t a;
    a.pred_a = p1_pred_a; a.pred_valid = p1_pred_valid; a.mismatch = p1_mismatch;
    a.err_sticky = p1_err_sticky; a.chk_cnt = int'(p1_chk_cnt); a.err_cnt = int'(p1_err_cnt);
    a.first_err = p1_first_err; a.fsm_state = p1_fsm_state;
    return a;
  endfunction

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input exp_t a);
    cmp({tag, ".pred_a"},     int'(a.pred_a),     int'(e.pred_a));
    cmp({tag, ".pred_valid"}, int'(a.pred_valid), int'(e.pred_valid));
    cmp({tag, ".mismatch"},   int'(a.mismatch),   int'(e.mismatch));
    cmp({tag, ".err_sticky"}, int'(a.err_sticky), int'(e.err_sticky));
    cmp({tag, ".chk_cnt"},    a.chk_cnt,          e.chk_cnt);
    cmp({tag, ".err_cnt"},    a.err_cnt,          e.err_cnt);
    cmp({tag, ".first_err"},  int'(a.first_err),  int'(e.first_err));
    cmp({tag, ".fsm_state"},  int'(a.fsm_state),  int'(e.fsm_state));
  endtask

  // Behavioural reference: what one checker shows after an edge with (en, s).
  task automatic modelStep(input int i, input logic e_n, input logic [3:0] s);
    logic wrong;
    model[i].mismatch = 1'b0;
    case (model[i].fsm_state)
      2'd0: begin
        if (e_n) begin
          model[i].fsm_state  = 2'd1;
          model[i].pred_a     = da_table[s];
          model[i].pred_valid = 1'b1;
        end
      end
      2'd1, 2'd2: begin
        if (!e_n) begin
          model[i].fsm_state  = 2'd0;
          model[i].pred_valid = 1'b0;
        end else begin
          wrong = (s[3] != model[i].pred_a);
          if (model[i].chk_cnt < cnt_max[i]) model[i].chk_cnt++;
          if (wrong) begin
            model[i].mismatch = 1'b1;
            if (model[i].err_cnt < cnt_max[i]) model[i].err_cnt++;
            if (!model[i].err_sticky) model[i].first_err = s;
            model[i].err_sticky = 1'b1;
          end
          model[i].pred_a = da_table[s];
          if (wrong && stop_mode[i]) begin
            model[i].fsm_state  = 2'd3;
            model[i].pred_valid = 1'b0;
          end else begin
            model[i].fsm_state = 2'd2;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic e_n, input logic [3:0] s);
    @(negedge clk);
    en       = e_n;
    state_in = s;
    modelStep(0, e_n, s);
    modelStep(1, e_n, s);
    q0.push_back(model[0]);
    q1.push_back(model[1]);
  endtask

  // Assert clear between edges and expect every output to drop at once.
  task automatic pulseClear();
    @(negedge clk);
    #2;
    clear = 1'b1;
    en    = 1'b0;
    #1;
    model[0] = zeroExp();
    model[1] = zeroExp();
    checkOutput("dut0_clear", model[0], actual0());
    checkOutput("dut1_clear", model[1], actual1());
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Monitor: after every rising edge, pop and compare any pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        mon_e = q0.pop_front();
        checkOutput("dut0", mon_e, actual0());
      end
      if (q1.size() > 0) begin
        mon_e = q1.pop_front();
        checkOutput("dut1", mon_e, actual1());
      end
    end
  end

  initial begin
    logic       a_bit;
    int         r;
    cnt_max[0]   = 255;
    cnt_max[1]   = 3;
    stop_mode[0] = 1'b0;
    stop_mode[1] = 1'b1;
    model[0] = zeroExp();
    model[1] = zeroExp();
    clear    = 1'b1;
    en       = 1'b0;
    state_in = 4'b0000;
    #12;
    checkOutput("dut0_reset", model[0], actual0());
    checkOutput("dut1_reset", model[1], actual1());
    @(negedge clk);
    clear = 1'b0;

    // Prime then match.
    applyStimulus(1'b1, 4'b0111);
    applyStimulus(1'b1, 4'b1000);

    // Chained matches.
    pulseClear();
    applyStimulus(1'b1, 4'b1010);
    applyStimulus(1'b1, 4'b1001);
    applyStimulus(1'b1, 4'b1100);
    applyStimulus(1'b1, 4'b0000);

    // Single error, then a later error that must not move first_err.
    pulseClear();
    applyStimulus(1'b1, 4'b0111);
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0101);
    applyStimulus(1'b1, 4'b1000);
    applyStimulus(1'b1, 4'b0111);

    // Enable drop mid-CHECK, then re-prime without comparing.
    pulseClear();
    applyStimulus(1'b1, 4'b0111);
    applyStimulus(1'b1, 4'b1000);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b1111);
    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b1, 4'b0000);

    // Saturation, an error after saturation, then clear mid-CHECK.
    pulseClear();
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0111);
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0000);
    pulseClear();

    // Randomized traffic biased toward matching the default checker.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pulseClear();
      end else begin
        a_bit = ($urandom_range(0, 9) < 7) ? model[0].pred_a : ~model[0].pred_a;
        applyStimulus(r >= 12, {a_bit, 3'($urandom_range(0, 7))});
      end
    end

    for (int k = 0; k < 5; k++) begin
      if ((q0.size() > 0) || (q1.size() > 0)) @(negedge clk);
    end
    cmp("scoreboard_drain", q0.size() + q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
